reg_to_mem_pipe: RTL

REG_TO_MEM_PIPE -- requirements
Module: reg_to_mem_pipe

---
 rtl/reg_to_mem_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_to_mem_pipe.sv
// Register-bus to single-port SRAM bridge: one outstanding access, one-cycle response pulse.
// Optional watchdog and stale-beat filtering are enabled by defining REG_TO_MEM_PIPE_TIMEOUT_EN.

package reg_to_mem_pipe_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module reg_to_mem_pipe #(
  parameter int             AW        = 10,
  parameter int             DW        = 32,
  parameter int             RAW       = 32,
  parameter logic [RAW-1:0] BASE_ADDR = '0,
  parameter int             TIMEOUT   = 64,
  parameter type            req_t     = reg_to_mem_pipe_pkg::reg_req_t,
  parameter type            rsp_t     = reg_to_mem_pipe_pkg::reg_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  req_t          reg_req_i,
  output rsp_t          reg_rsp_o,
  output logic          req_o,
  input  logic          gnt_i,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic [DW/8-1:0] wstrb_o,
  input  logic [DW-1:0] rdata_i,
  input  logic          rvalid_i,
  input  logic          rerror_i,
  output logic          busy_o
);

  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RD,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [RAW-1:0]  req_addr;
  logic [RAW-1:0]  off;
  logic            in_range;
  logic            load;
  logic            beat_ok;
  logic [DW-1:0]   rdata_q, rdata_n;
  logic            error_q, error_n;

`ifdef REG_TO_MEM_PIPE_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0]   cnt_q;
  logic            stale_q;
  logic            counting;
  logic            timeout_hit;
  logic            stale_set;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign beat_ok     = rvalid_i & ~stale_q;
`else
  assign beat_ok     = rvalid_i;
`endif

  // Window decode: anything below the base or past the last word is rejected without touching the SRAM.
  assign req_addr = RAW'(reg_req_i.addr);
  assign off      = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && ((off >> (AW + LSB)) == '0);

  assign addr_o  = AW'(off >> LSB);
  assign wdata_o = DW'(reg_req_i.wdata);
  assign wstrb_o = SW'(reg_req_i.wstrb);
  assign we_o    = req_o & reg_req_i.write;
  assign busy_o  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    req_o   = 1'b0;
    load    = 1'b0;
    rdata_n = '0;
    error_n = 1'b0;
`ifdef REG_TO_MEM_PIPE_TIMEOUT_EN
    counting  = 1'b0;
    stale_set = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (reg_req_i.valid) begin
          if (in_range) begin
            req_o = 1'b1;
            if (gnt_i) begin
              if (reg_req_i.write) begin
                state_d = RESP;
                load    = 1'b1;
              end else begin
                state_d = WAIT_RD;
              end
            end
`ifdef REG_TO_MEM_PIPE_TIMEOUT_EN
            else begin
              counting = 1'b1;
              if (timeout_hit) begin
                state_d = RESP;
                load    = 1'b1;
                error_n = 1'b1;
              end
            end
`endif
          end else begin
            state_d = RESP;
            load    = 1'b1;
            error_n = 1'b1;
          end
        end
      end
      WAIT_RD: begin
        if (beat_ok) begin
          state_d = RESP;
          load    = 1'b1;
          rdata_n = rdata_i;
          error_n = rerror_i;
        end
`ifdef REG_TO_MEM_PIPE_TIMEOUT_EN
        else begin
          counting = 1'b1;
          if (timeout_hit) begin
            state_d   = RESP;
            load      = 1'b1;
            error_n   = 1'b1;
            stale_set = 1'b1;
          end
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rdata_q <= rdata_n;
        error_q <= error_n;
      end
    end
  end

`ifdef REG_TO_MEM_PIPE_TIMEOUT_EN
  // The abandoned read's beat may still arrive later, in any state; the first one after a timeout is swallowed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      if ((state_d != state_q) || !counting) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (stale_set) begin
        stale_q <= 1'b1;
      end else if (rvalid_i) begin
        stale_q <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    reg_rsp_o = '0;
    if (state_q == RESP) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.rdata = rdata_q;
      reg_rsp_o.error = error_q;
    end
  end

endmodule
